elelock_prog: RTL



---
 rtl/elelock_pkg.sv | 35 +++
 rtl/elelock_keyenc.sv | 33 +++
 rtl/elelock_prog.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/elelock_pkg.sv
// elelock_pkg: shared types and helpers for the programmable ten-key lock.
//   state_e        : lock controller states
//   key_t          : decoded key {vld, digit}
//   onehot_decode  : ten-key one-hot pattern -> digit with valid flag
package elelock_pkg;

  localparam int DIGIT_W = 4;
  localparam int KEYS    = 10;

  typedef enum logic [1:0] {
    ST_OPEN    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_LOCKOUT = 2'd2,
    ST_PROG    = 2'd3
  } state_e;

  typedef struct packed {
    logic               vld;
    logic [DIGIT_W-1:0] digit;
  } key_t;

  // vld is set only for an exactly one-hot pattern; digit is the bit index.
  function automatic key_t onehot_decode(input logic [KEYS-1:0] keys);
    key_t res;
    res = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (keys == (KEYS'(1) << i)) begin
        res.vld   = 1'b1;
        res.digit = DIGIT_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/elelock_keyenc.sv
// elelock_keyenc: ten-key press detector and encoder.
// Ports:
//   ck, reset     clock / async active-low reset
//   tenkey_i      raw one-hot key inputs (bit n = digit n)
//   digit_vld_o   one-cycle strobe: key is one-hot now and previous sample was idle
//   digit_o       encoded digit (valid with digit_vld_o)
module elelock_keyenc
  import elelock_pkg::*;
(
  input  logic                ck,
  input  logic                reset,
  input  logic [KEYS-1:0]     tenkey_i,
  output logic                digit_vld_o,
  output logic [DIGIT_W-1:0]  digit_o
);

  logic [KEYS-1:0] prev_q;
  key_t            dec;

  // Any non-zero previous sample (held key or multi-hot) blocks acceptance,
  // so only a clean idle->one-hot transition counts.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) prev_q <= '0;
    else        prev_q <= tenkey_i;
  end

  always_comb begin
    dec         = onehot_decode(tenkey_i);
    digit_vld_o = dec.vld && (prev_q == '0);
    digit_o     = dec.digit;
  end

endmodule

// File: rtl/elelock_prog.sv
// elelock_prog: programmable DIGITS-digit electronic lock with optional lockout.
// Ports:
//   ck, reset   clock / async active-low reset
//   tenkey      one-hot key inputs
//   close       lock request (OPEN) / programming abort (PROG)
//   prog        enter programming mode (OPEN only)
//   lock        1 = bolt engaged
//   alarm       1 while in lockout
//   prog_mode   1 while in programming mode
//   key_cnt     digits collected in the current attempt
// Build option: ELELOCK_LOCKOUT_EN adds the fail counter, LOCKOUT state and
// timer; without it a mismatch just clears the entry and alarm stays 0.
module elelock_prog
  import elelock_pkg::*;
#(
  parameter int          DIGITS       = 4,
  parameter logic [31:0] DEFAULT_CODE = 32'h8596,
  parameter int          MAX_FAIL     = 3,
  parameter int          LOCKOUT_CYC  = 16
) (
  input  logic                         ck,
  input  logic                         reset,
  input  logic [KEYS-1:0]              tenkey,
  input  logic                         close,
  input  logic                         prog,
  output logic                         lock,
  output logic                         alarm,
  output logic                         prog_mode,
  output logic [$clog2(DIGITS+1)-1:0]  key_cnt
);

  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(DIGITS + 1);

  state_e               state_q;
  logic [CODE_W-1:0]    entry_q, entry_d, code_q;
  logic [CNT_W-1:0]     key_cnt_q;
  logic                 lock_q, alarm_q, prog_mode_q;
  logic                 digit_vld;
  logic [DIGIT_W-1:0]   digit;
  logic                 entry_full;

`ifdef ELELOCK_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int TMR_W  = $clog2(LOCKOUT_CYC + 1);
  logic [FAIL_W-1:0]    fail_q;
  logic [TMR_W-1:0]     timer_q;
`else
  logic                 unused_cfg;
  assign unused_cfg = ^{MAX_FAIL, LOCKOUT_CYC};
`endif

  elelock_keyenc u_keyenc (
    .ck          (ck),
    .reset       (reset),
    .tenkey_i    (tenkey),
    .digit_vld_o (digit_vld),
    .digit_o     (digit)
  );

  // Truncating cast keeps the newest DIGITS digits; MS digit entered first.
  assign entry_d    = CODE_W'({entry_q, digit});
  assign entry_full = (key_cnt_q == CNT_W'(DIGITS));

  // A full entry is evaluated on the edge after the final digit; digits
  // arriving on that evaluation edge are dropped.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_OPEN;
      entry_q     <= '0;
      code_q      <= DEFAULT_CODE[CODE_W-1:0];
      key_cnt_q   <= '0;
      lock_q      <= 1'b0;
      alarm_q     <= 1'b0;
      prog_mode_q <= 1'b0;
`ifdef ELELOCK_LOCKOUT_EN
      fail_q      <= '0;
      timer_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_OPEN: begin
          if (close) begin
            state_q <= ST_LOCKED;
            lock_q  <= 1'b1;
          end else if (prog) begin
            state_q     <= ST_PROG;
            prog_mode_q <= 1'b1;
          end
        end

        ST_LOCKED: begin
          if (entry_full) begin
            entry_q   <= '0;
            key_cnt_q <= '0;
            if (entry_q == code_q) begin
              state_q <= ST_OPEN;
              lock_q  <= 1'b0;
`ifdef ELELOCK_LOCKOUT_EN
              fail_q  <= '0;
`endif
            end
`ifdef ELELOCK_LOCKOUT_EN
            else if (fail_q == FAIL_W'(MAX_FAIL - 1)) begin
              state_q <= ST_LOCKOUT;
              alarm_q <= 1'b1;
              timer_q <= TMR_W'(LOCKOUT_CYC);
              fail_q  <= fail_q + 1'b1;
            end else begin
              fail_q  <= fail_q + 1'b1;
            end
`endif
          end else if (digit_vld) begin
            entry_q   <= entry_d;
            key_cnt_q <= key_cnt_q + 1'b1;
          end
        end

        ST_LOCKOUT: begin
`ifdef ELELOCK_LOCKOUT_EN
          // Leaving on the terminal count keeps alarm high for exactly LOCKOUT_CYC cycles.
          if (timer_q == TMR_W'(1)) begin
            state_q <= ST_LOCKED;
            alarm_q <= 1'b0;
            timer_q <= '0;
            fail_q  <= '0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
`else
          state_q <= ST_LOCKED;
          alarm_q <= 1'b0;
`endif
        end

        ST_PROG: begin
          if (close) begin
            state_q     <= ST_OPEN;
            prog_mode_q <= 1'b0;
            entry_q     <= '0;
            key_cnt_q   <= '0;
          end else if (entry_full) begin
            code_q      <= entry_q;
            state_q     <= ST_OPEN;
            prog_mode_q <= 1'b0;
            entry_q     <= '0;
            key_cnt_q   <= '0;
          end else if (digit_vld) begin
            entry_q   <= entry_d;
            key_cnt_q <= key_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_OPEN;
          lock_q  <= 1'b0;
        end
      endcase
    end
  end

  assign lock      = lock_q;
  assign alarm     = alarm_q;
  assign prog_mode = prog_mode_q;
  assign key_cnt   = key_cnt_q;

endmodule
